// File: rtl/handle_special_cmd_pkg.sv
// handle_special_cmd_pkg
//   Shared codes for the special-command handler: player selectors, game FSM
//   state codes, interboard message types for the special commands, and the
//   handler's own FSM state encoding.
//   No ports; imported by handle_special_cmd and its sub-modules.
package handle_special_cmd_pkg;

  // Player selectors
  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  // Game FSM state codes (cur_game_state)
  localparam logic [3:0] GAME_IDLE       = 4'd0;
  localparam logic [3:0] GAME_P1_WAIT_IN = 4'd1;
  localparam logic [3:0] GAME_P1_MOVE    = 4'd2;
  localparam logic [3:0] GAME_P1_SHIFT   = 4'd3;
  localparam logic [3:0] GAME_P2_WAIT_IN = 4'd4;
  localparam logic [3:0] GAME_P2_MOVE    = 4'd5;
  localparam logic [3:0] GAME_P2_SHIFT   = 4'd6;
  localparam logic [3:0] GAME_OVER       = 4'd7;

  // Interboard message types for special commands
  localparam logic [3:0] STATE_CHEAT  = 4'd9;
  localparam logic [3:0] STATE_UNDO   = 4'd10;
  localparam logic [3:0] STATE_REVEAL = 4'd11;
  localparam logic [3:0] STATE_HINT   = 4'd12;

  // Handler FSM states
  typedef enum logic [1:0] {
    HSC_IDLE = 2'd0,
    HSC_SEND = 2'd1,
    HSC_WAIT = 2'd2
  } hsc_state_e;

endpackage

// File: rtl/handle_special_cmd_prio_pick.sv
// prio_pick
//   Lowest-set-bit encoder: returns the index of the lowest asserted request.
//   Ports:
//     req   in  N      request vector
//     idx   out IDX_W  index of the lowest set bit (0 when none set)
//     valid out 1      any request set
module prio_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/handle_special_cmd.sv
// handle_special_cmd
//   Latches local special-command triggers (cheat, undo, reveal, ...),
//   arbitrates lowest-index-first, sends each over the interboard link with an
//   en/ready handshake, and tracks per-command activation from local sends and
//   remote messages.
//   Build option: define HSC_TIMEOUT_EN to add a WAIT_READY timeout that
//   re-sends the command after TIMEOUT_CYC cycles without inter_ready.
//   Ports:
//     clk, rst_n              clock, async active-low reset
//     interboard_rst          sync clear, same effect as reset
//     cmd_trigger[NUM_CMD]    local one-cycle request pulses
//     cur_game_state[4]       game FSM state (gates local triggers)
//     inter_ready             sender done pulse
//     interboard_en / _msg_type  received message valid / type
//     cmd_active[NUM_CMD]     per-command activation flags
//     busy                    high in SEND or WAIT_READY
//     cmd_ctrl_*              send request toward the interboard ctrl mux
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   HSC_IDLE | nothing in flight; grant lowest pending command
//   HSC_SEND | cmd_ctrl_en pulse for the granted command
//   HSC_WAIT | waiting for inter_ready, then apply local activation
module handle_special_cmd
  import handle_special_cmd_pkg::*;
#(
  parameter logic                 PLAYER        = P1,
  parameter int                   NUM_CMD       = 4,
  parameter logic [NUM_CMD*4-1:0] CMD_MSG_TYPES = {4'd0, 4'd0, 4'd0, STATE_CHEAT},
  parameter logic [NUM_CMD-1:0]   TOGGLE_MASK   = '0,
  parameter int                   TIMEOUT_CYC   = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               interboard_rst,
  input  logic [NUM_CMD-1:0] cmd_trigger,
  input  logic [3:0]         cur_game_state,
  input  logic               inter_ready,
  input  logic               interboard_en,
  input  logic [3:0]         interboard_msg_type,
  output logic [NUM_CMD-1:0] cmd_active,
  output logic               busy,
  output logic               cmd_ctrl_en,
  output logic [3:0]         cmd_ctrl_msg_type,
  output logic               cmd_ctrl_move_dir,
  output logic [4:0]         cmd_ctrl_block_x,
  output logic [2:0]         cmd_ctrl_block_y,
  output logic [5:0]         cmd_ctrl_card,
  output logic [2:0]         cmd_ctrl_sel_len
);

  localparam int IDX_W = (NUM_CMD > 1) ? $clog2(NUM_CMD) : 1;

  if (NUM_CMD < 1 || NUM_CMD > 8) begin : g_bad_num_cmd
    $error("handle_special_cmd: NUM_CMD must be 1..8");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("handle_special_cmd: TIMEOUT_CYC must be 1..65535");
  end

  hsc_state_e         state_q, state_d;
  logic [NUM_CMD-1:0] pend_q, pend_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [NUM_CMD-1:0] active_q, active_d;
  logic [3:0]         msg_type_q, msg_type_d;

  logic               player_ok;
  logic [NUM_CMD-1:0] pend_set, pend_clr;
  logic [NUM_CMD-1:0] local_hit, remote_hit, grant_oh, pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [3:0]         pick_msg;

`ifdef HSC_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
`endif

  prio_pick #(
    .N     (NUM_CMD),
    .IDX_W (IDX_W)
  ) u_prio_pick (
    .req   (pend_q),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    player_ok = 1'b0;
    if (PLAYER == P1) begin
      player_ok = (cur_game_state == GAME_P1_WAIT_IN) ||
                  (cur_game_state == GAME_P1_MOVE) ||
                  (cur_game_state == GAME_P1_SHIFT);
    end else begin
      player_ok = (cur_game_state == GAME_P2_WAIT_IN) ||
                  (cur_game_state == GAME_P2_MOVE) ||
                  (cur_game_state == GAME_P2_SHIFT);
    end
  end

  // Decode helpers: one-hot forms of the pick/grant indices, remote type match
  // (every matching nibble fires), and message type of the picked command.
  always_comb begin
    remote_hit = '0;
    grant_oh   = '0;
    pick_oh    = '0;
    pick_msg   = '0;
    for (int i = 0; i < NUM_CMD; i++) begin
      remote_hit[i] = interboard_en && (interboard_msg_type == CMD_MSG_TYPES[i*4 +: 4]);
      grant_oh[i]   = (grant_q == IDX_W'(i));
      pick_oh[i]    = (pick_idx == IDX_W'(i));
      if (pick_idx == IDX_W'(i)) pick_msg = CMD_MSG_TYPES[i*4 +: 4];
    end
  end

  // A trigger pends only if it is not already pending and the command can
  // still change state (toggles always can; sticky ones only while inactive).
  assign pend_set = cmd_trigger & ~pend_q & (TOGGLE_MASK | ~active_q) &
                    {NUM_CMD{player_ok}};

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    msg_type_d = msg_type_q;
    pend_clr   = '0;
    local_hit  = '0;
`ifdef HSC_TIMEOUT_EN
    tmo_cnt_d  = (state_q == HSC_WAIT) ? tmo_cnt_q + 16'd1 : 16'd0;
`endif

    case (state_q)
      HSC_IDLE: begin
        if (pick_vld) begin
          grant_d    = pick_idx;
          msg_type_d = pick_msg;
          pend_clr   = pick_oh;
          state_d    = HSC_SEND;
        end
      end
      HSC_SEND: begin
        state_d = HSC_WAIT;
      end
      HSC_WAIT: begin
        if (inter_ready) begin
          local_hit = grant_oh;
          state_d   = HSC_IDLE;
        end
`ifdef HSC_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d = HSC_SEND;
        end
`endif
      end
      default: begin
        state_d = HSC_IDLE;
      end
    endcase

    pend_d = (pend_q & ~pend_clr) | pend_set;

    // Toggle commands XOR both sources (same-cycle local+remote cancel);
    // sticky commands OR them in.
    active_d = (TOGGLE_MASK & (active_q ^ local_hit ^ remote_hit)) |
               (~TOGGLE_MASK & (active_q | local_hit | remote_hit));

    if (interboard_rst) begin
      state_d    = HSC_IDLE;
      pend_d     = '0;
      grant_d    = '0;
      active_d   = '0;
      msg_type_d = '0;
`ifdef HSC_TIMEOUT_EN
      tmo_cnt_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HSC_IDLE;
      pend_q     <= '0;
      grant_q    <= '0;
      active_q   <= '0;
      msg_type_q <= '0;
`ifdef HSC_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      grant_q    <= grant_d;
      active_q   <= active_d;
      msg_type_q <= msg_type_d;
`ifdef HSC_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  assign cmd_active        = active_q;
  assign busy              = (state_q != HSC_IDLE);
  assign cmd_ctrl_en       = (state_q == HSC_SEND);
  assign cmd_ctrl_msg_type = msg_type_q;
  assign cmd_ctrl_move_dir = 1'b0;
  assign cmd_ctrl_block_x  = '0;
  assign cmd_ctrl_block_y  = '0;
  assign cmd_ctrl_card     = '0;
  assign cmd_ctrl_sel_len  = '0;

endmodule

// File: tb/tb_handle_special_cmd.sv
// tb_handle_special_cmd
//   Directed bench for handle_special_cmd: four commands (cheat, undo, reveal,
//   hint), command 3 toggles, player P1. The timeout scenario is compiled in
//   only when HSC_TIMEOUT_EN is defined (TIMEOUT_CYC = 8).
module tb_handle_special_cmd;
  import handle_special_cmd_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       interboard_rst = 1'b0;
  logic [3:0] cmd_trigger = '0;
  logic [3:0] cur_game_state = GAME_P1_MOVE;
  logic       inter_ready = 1'b0;
  logic       interboard_en = 1'b0;
  logic [3:0] interboard_msg_type = '0;
  logic [3:0] cmd_active;
  logic       busy;
  logic       cmd_ctrl_en;
  logic [3:0] cmd_ctrl_msg_type;
  logic       cmd_ctrl_move_dir;
  logic [4:0] cmd_ctrl_block_x;
  logic [2:0] cmd_ctrl_block_y;
  logic [5:0] cmd_ctrl_card;
  logic [2:0] cmd_ctrl_sel_len;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  handle_special_cmd #(
    .PLAYER        (P1),
    .NUM_CMD       (4),
    .CMD_MSG_TYPES ({STATE_HINT, STATE_REVEAL, STATE_UNDO, STATE_CHEAT}),
    .TOGGLE_MASK   (4'b1000),
    .TIMEOUT_CYC   (8)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .interboard_rst      (interboard_rst),
    .cmd_trigger         (cmd_trigger),
    .cur_game_state      (cur_game_state),
    .inter_ready         (inter_ready),
    .interboard_en       (interboard_en),
    .interboard_msg_type (interboard_msg_type),
    .cmd_active          (cmd_active),
    .busy                (busy),
    .cmd_ctrl_en         (cmd_ctrl_en),
    .cmd_ctrl_msg_type   (cmd_ctrl_msg_type),
    .cmd_ctrl_move_dir   (cmd_ctrl_move_dir),
    .cmd_ctrl_block_x    (cmd_ctrl_block_x),
    .cmd_ctrl_block_y    (cmd_ctrl_block_y),
    .cmd_ctrl_card       (cmd_ctrl_card),
    .cmd_ctrl_sel_len    (cmd_ctrl_sel_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig(input logic [3:0] t);
    cmd_trigger = t;
    tick();
    cmd_trigger = '0;
  endtask

  task automatic ack();
    inter_ready = 1'b1;
    tick();
    inter_ready = 1'b0;
  endtask

  task automatic remote(input logic [3:0] t);
    interboard_en       = 1'b1;
    interboard_msg_type = t;
    tick();
    interboard_en       = 1'b0;
  endtask

  // Ticks until cmd_ctrl_en is seen (bounded); returns ticks taken.
  task automatic wait_en(input string tag, output int cnt);
    cnt = 0;
    while (cmd_ctrl_en !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({tag, " en_seen"}, 32'(cmd_ctrl_en), 32'd1);
  endtask

  task automatic count_en(input int cyc, output int pulses);
    pulses = 0;
    for (int i = 0; i < cyc; i++) begin
      tick();
      if (cmd_ctrl_en === 1'b1) pulses++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    // Reset values
    #22;
    chk("rst active", 32'(cmd_active), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst en", 32'(cmd_ctrl_en), 32'h0);
    chk("rst msg", 32'(cmd_ctrl_msg_type), 32'h0);
    chk("rst const", 32'({cmd_ctrl_move_dir, cmd_ctrl_block_x, cmd_ctrl_block_y,
                           cmd_ctrl_card, cmd_ctrl_sel_len}), 32'h0);
    rst_n = 1'b1;
    tick();

    // Cheat: en at t+2, ack 5 cycles later, then sticky
    pulse_trig(4'b0001);
    chk("cheat en t+1", 32'(cmd_ctrl_en), 32'h0);
    wait_en("cheat", n);
    chk("cheat latency", 32'(n), 32'd1);
    chk("cheat msg", 32'(cmd_ctrl_msg_type), 32'(STATE_CHEAT));
    chk("cheat busy", 32'(busy), 32'h1);
    chk("send const", 32'({cmd_ctrl_move_dir, cmd_ctrl_block_x, cmd_ctrl_block_y,
                           cmd_ctrl_card, cmd_ctrl_sel_len}), 32'h0);
    tick();
    chk("cheat en single", 32'(cmd_ctrl_en), 32'h0);
    chk("cheat wait busy", 32'(busy), 32'h1);
    chk("cheat wait msg", 32'(cmd_ctrl_msg_type), 32'(STATE_CHEAT));
    repeat (4) tick();
    ack();
    chk("cheat active", 32'(cmd_active), 32'h1);
    chk("cheat idle", 32'(busy), 32'h0);
    pulse_trig(4'b0001);
    count_en(6, n);
    chk("cheat retrig dropped", 32'(n), 32'd0);

    // Two triggers in one cycle: lowest first, one-cycle IDLE gap
    pulse_trig(4'b0110);
    wait_en("dual1", n);
    chk("dual1 latency", 32'(n), 32'd1);
    chk("dual1 msg", 32'(cmd_ctrl_msg_type), 32'(STATE_UNDO));
    tick();
    ack();
    chk("dual1 active", 32'(cmd_active), 32'h3);
    wait_en("dual2", n);
    chk("dual2 gap", 32'(n), 32'd1);
    chk("dual2 msg", 32'(cmd_ctrl_msg_type), 32'(STATE_REVEAL));
    tick();
    ack();
    chk("dual2 active", 32'(cmd_active), 32'h7);
    count_en(5, n);
    chk("dual no extra en", 32'(n), 32'd0);

    // Toggle command 3
    pulse_trig(4'b1000);
    wait_en("tog1", n);
    chk("tog1 msg", 32'(cmd_ctrl_msg_type), 32'(STATE_HINT));
    tick();
    ack();
    chk("tog1 active", 32'(cmd_active), 32'hF);
    pulse_trig(4'b1000);
    wait_en("tog2", n);
    tick();
    ack();
    chk("tog2 active", 32'(cmd_active), 32'h7);
    pulse_trig(4'b1000);
    wait_en("tog3", n);
    tick();
    inter_ready         = 1'b1;
    interboard_en       = 1'b1;
    interboard_msg_type = STATE_HINT;
    tick();
    inter_ready   = 1'b0;
    interboard_en = 1'b0;
    chk("tog local+remote", 32'(cmd_active), 32'h7);
    chk("tog3 idle", 32'(busy), 32'h0);
    remote(STATE_HINT);
    chk("tog remote", 32'(cmd_active), 32'hF);
    remote(4'd15);
    chk("remote nomatch", 32'(cmd_active), 32'hF);

    // inter_ready in IDLE is ignored
    ack();
    chk("stray ready active", 32'(cmd_active), 32'hF);
    chk("stray ready busy", 32'(busy), 32'h0);

    // Sync clear, then wrong player's state
    interboard_rst = 1'b1;
    tick();
    interboard_rst = 1'b0;
    chk("ibrst active", 32'(cmd_active), 32'h0);
    cur_game_state = GAME_P2_MOVE;
    pulse_trig(4'b0001);
    count_en(6, n);
    chk("p2 state no en", 32'(n), 32'd0);
    chk("p2 state busy", 32'(busy), 32'h0);
    remote(STATE_CHEAT);
    chk("remote cheat", 32'(cmd_active), 32'h1);

    // Trigger during WAIT pends; leaving player_ok keeps it pending
    cur_game_state = GAME_P1_WAIT_IN;
    pulse_trig(4'b0010);
    wait_en("inflight1", n);
    chk("inflight1 msg", 32'(cmd_ctrl_msg_type), 32'(STATE_UNDO));
    tick();
    pulse_trig(4'b0100);
    cur_game_state = GAME_P2_SHIFT;
    tick();
    ack();
    chk("inflight1 active", 32'(cmd_active), 32'h3);
    wait_en("inflight2", n);
    chk("inflight2 gap", 32'(n), 32'd1);
    chk("inflight2 msg", 32'(cmd_ctrl_msg_type), 32'(STATE_REVEAL));
    tick();
    ack();
    chk("inflight2 active", 32'(cmd_active), 32'h7);

    // interboard_rst with one in flight and one pending
    cur_game_state = GAME_P1_SHIFT;
    interboard_rst = 1'b1;
    tick();
    interboard_rst = 1'b0;
    pulse_trig(4'b0011);
    wait_en("ibrst pend", n);
    chk("ibrst pend msg", 32'(cmd_ctrl_msg_type), 32'(STATE_CHEAT));
    tick();
    interboard_rst = 1'b1;
    tick();
    interboard_rst = 1'b0;
    chk("ibrst busy", 32'(busy), 32'h0);
    chk("ibrst msg", 32'(cmd_ctrl_msg_type), 32'h0);
    chk("ibrst active2", 32'(cmd_active), 32'h0);
    count_en(8, n);
    chk("ibrst no en", 32'(n), 32'd0);

    // Async reset in WAIT_READY
    remote(STATE_CHEAT);
    pulse_trig(4'b0100);
    wait_en("arst", n);
    tick();
    chk("arst pre busy", 32'(busy), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy), 32'h0);
    chk("arst en", 32'(cmd_ctrl_en), 32'h0);
    chk("arst msg", 32'(cmd_ctrl_msg_type), 32'h0);
    chk("arst active", 32'(cmd_active), 32'h0);
    rst_n = 1'b1;
    tick();
    count_en(5, n);
    chk("arst no en", 32'(n), 32'd0);

`ifdef HSC_TIMEOUT_EN
    // No inter_ready: en re-pulses every 10 cycles until acknowledged
    pulse_trig(4'b0001);
    wait_en("tmo0", n);
    tick();
    wait_en("tmo1", n);
    chk("tmo period1", 32'(n + 1), 32'd10);
    chk("tmo msg", 32'(cmd_ctrl_msg_type), 32'(STATE_CHEAT));
    tick();
    wait_en("tmo2", n);
    chk("tmo period2", 32'(n + 1), 32'd10);
    tick();
    ack();
    chk("tmo active", 32'(cmd_active), 32'h1);
    count_en(20, n);
    chk("tmo retries end", 32'(n), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/handle_special_cmd.md
Name: handle_special_cmd

Overview:
- Parametrised successor to the single-purpose cheat handler; manages NUM_CMD independent special commands (cheat, undo-request, reveal, etc.).
- Latches local trigger pulses and arbitrates among pending commands.
- Sends each command over the interboard link with an en/ready handshake, and tracks per-command activation from both local sends and remote messages.
- Sits between mouse/keyboard gesture detectors and the interboard ctrl mux in GameControl.

Parameters:
- PLAYER, 0: `P1 or `P2; selects which game states allow local triggers.
- NUM_CMD, 4: number of command channels (1..8).
- CMD_MSG_TYPES, {4'd0,4'd0,4'd0,`STATE_CHEAT}: packed NUM_CMD×4. Nibble i is the message type for command i.
- TOGGLE_MASK, 0: bit i=1 makes command i toggle; bit i=0 makes it one-shot sticky (set once, like cheat).
- TIMEOUT_CYC, 1024: handshake timeout in cycles. Used only with HSC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- interboard_rst  in  1  synchronous clear, same effect as reset
- cmd_trigger  in  NUM_CMD  one-cycle local request pulses, one per command
- cur_game_state  in  4  current game FSM state
- inter_ready  in  1  interboard sender done pulse
- interboard_en  in  1  received-message valid pulse
- interboard_msg_type  in  4  received message type
- cmd_active  out  NUM_CMD  per-command activation flags
- busy  out  1  high in SEND or WAIT_READY
- cmd_ctrl_en  out  1  one-cycle send request
- cmd_ctrl_msg_type  out  4  message type of the granted command
- cmd_ctrl_move_dir  out  1  constant 0
- cmd_ctrl_block_x  out  5  constant 0
- cmd_ctrl_block_y  out  3  constant 0
- cmd_ctrl_card  out  6  constant 0
- cmd_ctrl_sel_len  out  3  constant 0

Behaviour:
- Reset (rst_n low, async) or interboard_rst (sync) clears: state=IDLE, pend=0, grant=0, cmd_active=0, cmd_ctrl_en=0, cmd_ctrl_msg_type=0, timeout counter=0.
- player_ok is true when cur_game_state is one of this PLAYER's WAIT_IN, MOVE or SHIFT states.
- Pend set: pend[i] sets on cmd_trigger[i] only when all of the following hold:
  - player_ok is true;
  - pend[i] is 0;
  - the command is re-triggerable, i.e. TOGGLE_MASK[i]=1 or cmd_active[i]=0.
  - Any other trigger is dropped. Several triggers in one cycle may all pend.
- FSM IDLE:
  - If pend is nonzero, grant = lowest set index, clear pend[grant], go to SEND.
  - The grant is registered; cmd_ctrl_msg_type = CMD_MSG_TYPES[grant].
- FSM SEND: cmd_ctrl_en=1 for exactly this cycle, then go to WAIT_READY.
- FSM WAIT_READY:
  - On inter_ready, apply local activation to cmd_active[grant] (set, or toggle if TOGGLE_MASK), then go to IDLE.
  - cmd_ctrl_msg_type stays stable from SEND through WAIT_READY.
- Latency: trigger at cycle t, then cmd_ctrl_en at t+2; cmd_active updates the cycle after inter_ready. Back-to-back commands have a one-cycle IDLE gap.
- Remote message: interboard_en with interboard_msg_type == CMD_MSG_TYPES[i] applies activation to cmd_active[i] next cycle, in any state.
  - A duplicate match on multiple nibbles applies to all matching indices.
- Local and remote activation of the same index in one cycle:
  - set commands: result is 1;
  - toggle commands: net no change (XOR of both).
- Triggers during SEND/WAIT_READY still pend. Leaving player_ok does not abort an in-flight send or clear pend.
- inter_ready outside WAIT_READY is ignored.

Optional Feature:
- HSC_TIMEOUT_EN defined: a 16-bit counter runs in WAIT_READY. If TIMEOUT_CYC cycles elapse without inter_ready, return to SEND and re-pulse cmd_ctrl_en. The counter clears on entering SEND.
- HSC_TIMEOUT_EN undefined: WAIT_READY waits indefinitely, and no counter is synthesised.

Decomposition:
- game_macro.v: game state codes (`GAME_Px_*`, `P1/`P2).
- message_macro.v: message types (`STATE_CHEAT` and new command types).
- Add HSC_IDLE/HSC_SEND/HSC_WAIT state codes to game_macro.v.
- One sub-module: prio_pick, a parametrised lowest-set-bit encoder (NUM_CMD in, index and valid out).

Test Plan:
- PLAYER=`P1, state=GAME_P1_MOVE, cmd_trigger=4'b0001 -> cmd_ctrl_en at t+2, msg_type=`STATE_CHEAT; inter_ready 5 cycles later -> cmd_active=4'b0001; further trigger[0] is ignored.
- cmd_trigger=4'b0110 in the same cycle, TOGGLE_MASK=0 -> sends index 1 then index 2, each with one en pulse; cmd_active=4'b0110 after two inter_ready pulses.
- State=GAME_P2_MOVE with PLAYER=`P1, trigger[0] -> no en; interboard_en with msg_type=`STATE_CHEAT -> cmd_active[0]=1 next cycle.
- TOGGLE_MASK=4'b1000: trigger[3] twice, each acknowledged -> cmd_active[3] goes 1 then 0; remote and local toggle in the same cycle -> unchanged.
- Assert rst_n low asynchronously mid WAIT_READY -> all outputs 0 immediately; interboard_rst while pending -> pend cleared, no en afterwards.
- With HSC_TIMEOUT_EN, TIMEOUT_CYC=8 and no inter_ready -> cmd_ctrl_en re-pulses every 10 cycles; inter_ready then ends retries.
